// File: rtl/pci_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pci_arb_pkg
// Brief    : Shared constants and state encoding for the PCI bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pci_arb_pkg;

    localparam int C_N_REQ       = 8;
    localparam int C_GNT_TIMEOUT = 16;

    localparam logic [1:0] MODE_PRIO = 2'b00;
    localparam logic [1:0] MODE_RR   = 2'b01;
    localparam logic [1:0] MODE_FCFS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pci_fcfs_queue.sv
`default_nettype none
// ============================================================================
// Module   : pci_fcfs_queue
// Brief    : Ordered arrival queue of requester indices with multi-enqueue,
//            arbitrary removal and same-cycle compaction.
// Revision : 1.0 - initial release
// ============================================================================
module pci_fcfs_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] i_enq_mask,
    input  logic [DEPTH-1:0] i_rm_mask,
    output logic [IDX_W-1:0] o_head,
    output logic             o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] r_slot [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [IDX_W-1:0] w_slot [DEPTH];
    logic [CNT_W-1:0] w_count;
    logic [DEPTH-1:0] w_kept;

    // head/empty reflect this cycle's removals and arrivals, so a lone new
    // requester can win arbitration on the same edge it is enqueued.
    always_comb begin
        w_slot  = '{default: '0};
        w_count = '0;
        w_kept  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) && !i_rm_mask[r_slot[i]]) begin
                w_slot[w_count[IDX_W-1:0]] = r_slot[i];
                w_kept[r_slot[i]]          = 1'b1;
                w_count                    = w_count + CNT_W'(1);
            end
        end
        for (int d = 0; d < DEPTH; d++) begin
            if (i_enq_mask[d] && !w_kept[d] && (w_count < CNT_W'(DEPTH))) begin
                w_slot[w_count[IDX_W-1:0]] = IDX_W'(d);
                w_count                    = w_count + CNT_W'(1);
            end
        end
    end

    assign o_head  = w_slot[0];
    assign o_empty = (w_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot  <= '{default: '0};
            r_count <= '0;
        end else begin
            r_slot  <= w_slot;
            r_count <= w_count;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pci_bus_arbiter
// Brief    : Central eight-device PCI arbiter with priority, round-robin and
//            FCFS policies; grants change hands only at bus-idle boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_REQ       = C_N_REQ,
    parameter int GNT_TIMEOUT = C_GNT_TIMEOUT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ_N,
    input  logic [1:0]               MODE,
    input  logic                     FRAME_N,
    input  logic                     IRDY_N,
    output logic [N_REQ-1:0]         GNT_N,
    output logic                     GNT_VALID,
    output logic [$clog2(N_REQ)-1:0] GNT_IDX
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt_n, w_gnt_n_nxt;
    logic             r_gnt_valid, w_gnt_valid_nxt;
    logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_release;

    logic [N_REQ-1:0] w_req;
    logic [N_REQ-1:0] w_hold;
    logic [N_REQ-1:0] w_pop;
    logic [IDX_W-1:0] w_prio_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_rr_cand;
    logic             w_rr_found;
    logic [IDX_W-1:0] w_fcfs_head;
    logic             w_fcfs_empty;
    logic [IDX_W-1:0] w_winner;

    assign w_req  = ~REQ_N;
    assign w_hold = (r_gnt_valid && !w_release) ? ~r_gnt_n : '0;
    assign w_pop  = w_release ? (N_REQ'(1) << r_gnt_idx) : '0;

    pci_fcfs_queue #(
        .DEPTH (N_REQ),
        .IDX_W (IDX_W)
    ) u_fcfs_queue (
        .clk        (CLK),
        .rst        (RST),
        .i_enq_mask (w_req & ~w_hold),
        .i_rm_mask  (~w_req | w_pop),
        .o_head     (w_fcfs_head),
        .o_empty    (w_fcfs_empty)
    );

    always_comb begin
        w_prio_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req[i]) w_prio_idx = IDX_W'(i);
        end
    end

    // Offset N_REQ wraps to the pointer itself, so the last granted device
    // is considered only after every other requester.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_cand  = '0;
        w_rr_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_rr_cand = r_rr_ptr + IDX_W'(k);
            if (!w_rr_found && w_req[w_rr_cand]) begin
                w_rr_idx   = w_rr_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (MODE)
            MODE_RR:   w_winner = w_rr_idx;
            MODE_FCFS: w_winner = w_fcfs_empty ? w_prio_idx : w_fcfs_head;
            default:   w_winner = w_prio_idx;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_n_nxt     = r_gnt_n;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_cnt_nxt       = r_cnt;
        w_release       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt     = ST_GRANTED;
                    w_gnt_n_nxt     = ~(N_REQ'(1) << w_winner);
                    w_gnt_valid_nxt = 1'b1;
                    w_gnt_idx_nxt   = w_winner;
                    w_cnt_nxt       = '0;
                end
            end
            ST_GRANTED: begin
                if (!FRAME_N) begin
                    w_state_nxt = ST_BUSY;
                end else if (!w_req[r_gnt_idx] || (r_cnt == CNT_W'(GNT_TIMEOUT - 1))) begin
                    w_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (FRAME_N && IRDY_N) w_release = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_release) begin
            w_state_nxt     = ST_IDLE;
            w_gnt_n_nxt     = '1;
            w_gnt_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_gnt_n     <= '1;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= IDX_W'(N_REQ - 1);
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_n     <= w_gnt_n_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_release) r_rr_ptr <= r_gnt_idx;
        end
    end

    assign GNT_N     = r_gnt_n;
    assign GNT_VALID = r_gnt_valid;
    assign GNT_IDX   = r_gnt_idx;

endmodule
`default_nettype wire
